// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with tear-free double buffering,
// per-digit blanking/blinking, decimal points and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n_i,
  input  logic                  hold_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic [DIGITS-1:0]     blink_i,
  input  logic                  lz_en_i,
  output logic [DIGITS-1:0]     an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o,
  output logic                  pend_o
);

  localparam int IW = (DIGITS > 2) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_FRAMES - 1);

  // Active-high abcdefg pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  logic [CW-1:0]         cnt_r;
  logic [IW-1:0]         idx_r;
  logic [BW-1:0]         blink_cnt_r;
  logic                  blink_ph_r;

  logic                  pend_r;
  logic [4*DIGITS-1:0]   pend_data_r;
  logic [DIGITS-1:0]     pend_dp_r;
  logic [DIGITS-1:0]     pend_blank_r;
  logic [DIGITS-1:0]     pend_blink_r;

  logic [4*DIGITS-1:0]   sh_data_r;
  logic [DIGITS-1:0]     sh_dp_r;
  logic [DIGITS-1:0]     sh_blank_r;
  logic [DIGITS-1:0]     sh_blink_r;

  logic [DIGITS-1:0]     an_r;
  logic [6:0]            seg_r;
  logic                  dp_r;
  logic                  frame_r;

  logic                  tick_s;
  logic                  wrap_s;
  logic                  commit_s;
  logic [DIGITS-1:0]     lz_mask_s;
  logic [DIGITS-1:0]     an_dec_s;
  logic [3:0]            nib_s;
  logic                  dp_sel_s;
  logic                  blank_sel_s;
  logic                  blink_sel_s;
  logic                  lz_sel_s;
  logic                  vis_s;

  // Slot and frame boundary decode; hold freezes the scan so no tick can occur.
  always_comb begin
    tick_s   = (~hold_i) & (cnt_r == CNT_LAST);
    wrap_s   = tick_s & (idx_r == IDX_LAST);
    commit_s = pend_r & (wrap_s | hold_i);
  end

  // Prescaler: one digit slot is SCAN_DIV cycles.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r <= {CW{1'b0}};
    end else if (hold_i || tick_s) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Digit index walks 0..DIGITS-1 once per slot.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_r <= {IW{1'b0}};
    end else if (hold_i) begin
      idx_r <= {IW{1'b0}};
    end else if (tick_s) begin
      idx_r <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Blink phase flips after every BLINK_FRAMES completed frames.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      blink_cnt_r <= {BW{1'b0}};
      blink_ph_r  <= 1'b0;
    end else if (wrap_s) begin
      if (blink_cnt_r == BLK_LAST) begin
        blink_cnt_r <= {BW{1'b0}};
        blink_ph_r  <= ~blink_ph_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
        blink_ph_r  <= blink_ph_r;
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
      blink_ph_r  <= blink_ph_r;
    end
  end

  // Pending buffer: a new load always wins, even on the cycle the old contents commit.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_r       <= 1'b0;
      pend_data_r  <= {(4*DIGITS){1'b0}};
      pend_dp_r    <= {DIGITS{1'b0}};
      pend_blank_r <= {DIGITS{1'b0}};
      pend_blink_r <= {DIGITS{1'b0}};
    end else if (load_i) begin
      pend_r       <= 1'b1;
      pend_data_r  <= data_i;
      pend_dp_r    <= dp_i;
      pend_blank_r <= blank_i;
      pend_blink_r <= blink_i;
    end else if (commit_s) begin
      pend_r       <= 1'b0;
    end else begin
      pend_r       <= pend_r;
    end
  end

  // Shadow buffer only changes at a frame boundary or under hold, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_data_r  <= {(4*DIGITS){1'b0}};
      sh_dp_r    <= {DIGITS{1'b0}};
      sh_blank_r <= {DIGITS{1'b0}};
      sh_blink_r <= {DIGITS{1'b0}};
    end else if (commit_s) begin
      sh_data_r  <= pend_data_r;
      sh_dp_r    <= pend_dp_r;
      sh_blank_r <= pend_blank_r;
      sh_blink_r <= pend_blink_r;
    end else begin
      sh_data_r  <= sh_data_r;
      sh_dp_r    <= sh_dp_r;
      sh_blank_r <= sh_blank_r;
      sh_blink_r <= sh_blink_r;
    end
  end

  // Leading-zero mask: a digit is dark when it and every digit above it are zero.
  always_comb begin
    logic run_v;
    lz_mask_s = {DIGITS{1'b0}};
    run_v     = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run_v        = run_v & (sh_data_r[4*k +: 4] == 4'h0);
      lz_mask_s[k] = lz_en_i & run_v;
    end
  end

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    nib_s       = 4'h0;
    dp_sel_s    = 1'b0;
    blank_sel_s = 1'b0;
    blink_sel_s = 1'b0;
    lz_sel_s    = 1'b0;
    an_dec_s    = {DIGITS{1'b1}};
    for (int k = 0; k < DIGITS; k++) begin
      nib_s       = (idx_r == IW'(k)) ? sh_data_r[4*k +: 4] : nib_s;
      dp_sel_s    = (idx_r == IW'(k)) ? sh_dp_r[k]          : dp_sel_s;
      blank_sel_s = (idx_r == IW'(k)) ? sh_blank_r[k]       : blank_sel_s;
      blink_sel_s = (idx_r == IW'(k)) ? sh_blink_r[k]       : blink_sel_s;
      lz_sel_s    = (idx_r == IW'(k)) ? lz_mask_s[k]        : lz_sel_s;
      an_dec_s[k] = (idx_r != IW'(k));
    end
    vis_s = ~(blank_sel_s | (blink_sel_s & blink_ph_r) | lz_sel_s);
  end

  // Registered drive stage; hold and invisible digits both force every line inactive.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      an_r    <= {DIGITS{1'b1}};
      seg_r   <= 7'h7F;
      dp_r    <= 1'b1;
      frame_r <= 1'b0;
    end else if (hold_i) begin
      an_r    <= {DIGITS{1'b1}};
      seg_r   <= 7'h7F;
      dp_r    <= 1'b1;
      frame_r <= 1'b0;
    end else if (vis_s) begin
      an_r    <= an_dec_s;
      seg_r   <= ~hex_to_seg(nib_s);
      dp_r    <= ~dp_sel_s;
      frame_r <= wrap_s;
    end else begin
      an_r    <= {DIGITS{1'b1}};
      seg_r   <= 7'h7F;
      dp_r    <= 1'b1;
      frame_r <= wrap_s;
    end
  end

  assign an_o    = an_r;
  assign seg_o   = seg_r;
  assign dp_o    = dp_r;
  assign frame_o = frame_r;
  assign pend_o  = pend_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        hold_i;
  logic        load_i;
  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic [7:0]  blank_i;
  logic [7:0]  blink_i;
  logic        lz_en_i;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic        frame_o;
  logic        pend_o;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n_i(rst_n_i), .hold_i(hold_i), .load_i(load_i),
    .data_i(data_i), .dp_i(dp_i), .blank_i(blank_i), .blink_i(blink_i),
    .lz_en_i(lz_en_i), .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o),
    .frame_o(frame_o), .pend_o(pend_o)
  );

  typedef struct {
    int         stamp;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fr;
    logic       pd;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  // Active-low segment patterns for hex 0..F.
  logic [6:0] segn [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic push(input int st, input logic [7:0] an, input logic [6:0] seg,
                      input logic dp, input logic fr, input logic pd, input string nm);
    exp_t x;
    x.stamp = st; x.an = an; x.seg = seg; x.dp = dp; x.fr = fr; x.pd = pd; x.name = nm;
    q.push_back(x);
  endtask

  task automatic push_digit(input int st, input logic [31:0] dat, input logic [7:0] dpm,
                            input int d, input logic dark, input logic fr, input logic pd,
                            input string nm);
    if (dark) push(st, 8'hFF, 7'h7F, 1'b1, fr, pd, nm);
    else      push(st, ~(8'h01 << d), segn[dat[4*d +: 4]], ~dpm[d], fr, pd, nm);
  endtask

  // Monitor: one sample per negedge, compare every expectation stamped for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      while (q.size() != 0 && q[0].stamp <= cyc) begin
        e = q.pop_front();
        n_chk = n_chk + 1;
        if (e.stamp < cyc) begin
          $display("FAIL %s stale expectation stamp=%0d at cycle %0d", e.name, e.stamp, cyc);
        end else if ({an_o, seg_o, dp_o, frame_o, pend_o} === {e.an, e.seg, e.dp, e.fr, e.pd}) begin
          n_pass = n_pass + 1;
        end else begin
          $display("FAIL %s @%0d: got an=%h seg=%h dp=%b fr=%b pd=%b, want an=%h seg=%h dp=%b fr=%b pd=%b",
                   e.name, cyc, an_o, seg_o, dp_o, frame_o, pend_o, e.an, e.seg, e.dp, e.fr, e.pd);
        end
      end
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] dat, input logic [7:0] dpm,
                         input logic [7:0] blk, input logic [7:0] bln);
    data_i = dat; dp_i = dpm; blank_i = blk; blink_i = bln; load_i = 1'b1;
    adv(1);
    load_i = 1'b0;
  endtask

  // Load under hold (commits immediately), check the held state, then release.
  task automatic hold_load(input logic [31:0] dat, input logic [7:0] dpm,
                           input logic [7:0] bln, output int rel0);
    hold_i = 1'b1;
    do_load(dat, dpm, 8'h00, bln);
    adv(1);
    push(cyc + 1, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0, "hold");
    hold_i = 1'b0;
    rel0   = cyc + 1;
  endtask

  int          rel0;
  int          j;
  int          d;
  logic [31:0] dat;
  logic [7:0]  dpm;
  logic        pd;

  initial begin
    rst_n_i = 1'b0; hold_i = 1'b1; load_i = 1'b0; data_i = 32'h0;
    dp_i = 8'h00; blank_i = 8'h00; blink_i = 8'h00; lz_en_i = 1'b0;
    adv(1);
    push(cyc + 1, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0, "reset");
    adv(1);
    rst_n_i = 1'b1;

    // Blink: digit 0 blinks, dark in frames 2-3 and 6-7.
    hold_load(32'h00000008, 8'h00, 8'h01, rel0);
    for (int f = 0; f < 8; f++) begin
      push_digit(rel0 + 32*f + 1, 32'h8, 8'h00, 0, (f % 4) >= 2, 1'b0, 1'b0, "blink");
      push_digit(rel0 + 32*f + 4, 32'h8, 8'h00, 0, (f % 4) >= 2, 1'b0, 1'b0, "blink");
      push_digit(rel0 + 32*f + 5, 32'h8, 8'h00, 1, 1'b0,         1'b0, 1'b0, "blink1");
    end
    adv(240);
    do_load(32'hAAAAAAAA, 8'h00, 8'h00, 8'h00);
    push(cyc + 1, 8'hEF, 7'h40, 1'b1, 1'b0, 1'b1, "pend");
    adv(1);
    push(cyc + 1, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0, "async_rst");
    rst_n_i = 1'b0;
    adv(2);
    rst_n_i = 1'b1;

    // Scan, tear-free load, last-write-wins and wrap-cycle collision.
    hold_load(32'h01234567, 8'h05, 8'h00, rel0);
    for (j = 1; j <= 136; j++) begin
      if (j <= 32)      begin dat = 32'h01234567; dpm = 8'h05; end
      else if (j <= 96) begin dat = 32'hFFFFFFFF; dpm = 8'h00; end
      else if (j <= 128) begin dat = 32'h22222222; dpm = 8'h00; end
      else              begin dat = 32'h33333333; dpm = 8'h00; end
      pd = ((j >= 11) && (j <= 31)) || ((j >= 70) && (j <= 127));
      push_digit(rel0 + j, dat, dpm, ((j - 1) / 4) % 8, 1'b0, (j % 32) == 0, pd,
                 (j > 96) ? "collide" : "scan");
    end
    adv(10);
    do_load(32'hFFFFFFFF, 8'h00, 8'h00, 8'h00);
    adv(58);
    do_load(32'h99999999, 8'h00, 8'h00, 8'h00);
    adv(9);
    do_load(32'h22222222, 8'h00, 8'h00, 8'h00);
    adv(15);
    do_load(32'h33333333, 8'h00, 8'h00, 8'h00);
    adv(45);

    // Leading-zero suppression on an all-zero word: only digit 0 lit.
    lz_en_i = 1'b1;
    hold_load(32'h00000000, 8'h00, 8'h00, rel0);
    for (j = 1; j <= 8; j++) begin
      d = (j - 1) / 4;
      push_digit(rel0 + j, 32'h0, 8'h00, d, d != 0, 1'b0, 1'b0, "lz0");
    end
    adv(10);

    // Leading-zero with 0x00100000, then a hold pulse mid-slot and restart.
    hold_load(32'h00100000, 8'h00, 8'h00, rel0);
    for (j = 1; j <= 38; j++) begin
      d = ((j - 1) / 4) % 8;
      push_digit(rel0 + j, 32'h00100000, 8'h00, d, d >= 6, j == 32, 1'b0, "lz5");
    end
    push(rel0 + 39, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0, "holdp");
    for (j = 1; j <= 8; j++) begin
      push_digit(rel0 + 39 + j, 32'h00100000, 8'h00, (j - 1) / 4, 1'b0, 1'b0, 1'b0, "restart");
    end
    adv(38);
    hold_i = 1'b1;
    adv(1);
    hold_i = 1'b0;
    adv(12);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_chk = n_chk + 1;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter SCAN_DIV, default 100000, clock cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 32, full scan frames per blink half-period (legal >= 1).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port hold_i  input  1  scan freeze and blank request.
REQ-007 SHALL have port load_i  input  1  single-cycle strobe capturing the display inputs.
REQ-008 SHALL have port data_i  input  4*DIGITS  hex nibbles; nibble k (bits 4k+3:4k) drives digit k.
REQ-009 SHALL have port dp_i  input  DIGITS  decimal-point request per digit, 1 = lit.
REQ-010 SHALL have port blank_i  input  DIGITS  forced blank per digit, 1 = off.
REQ-011 SHALL have port blink_i  input  DIGITS  blink enable per digit.
REQ-012 SHALL have port lz_en_i  input  1  leading-zero suppression enable (sampled live, not double-buffered).
REQ-013 SHALL have port an_o  output  DIGITS  digit enables, active-low; bit k = digit k.
REQ-014 SHALL have port seg_o  output  7  segments a..g on bits 0..6, active-low.
REQ-015 SHALL have port dp_o  output  1  decimal point, active-low.
REQ-016 SHALL have port frame_o  output  1  one-cycle pulse at each frame wrap.
REQ-017 SHALL have port pend_o  output  1  high while captured data awaits commit.

Function
REQ-018 SHALL count cycles 0..SCAN_DIV-1 in a prescaler; tick = count at SCAN_DIV-1; count wraps to 0 on tick.
REQ-019 SHALL advance digit index on tick: 0,1,..,DIGITS-1, wrapping to 0; the wrap cycle is the frame wrap.
REQ-020 SHALL register all outputs; an_o/seg_o/dp_o reflect the index one cycle after it changes.
REQ-021 SHALL drive an_o with only bit[index] low when the digit is visible; all ones otherwise.
REQ-022 SHALL encode active-high abcdefg 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71, then output the bitwise inverse on seg_o.
REQ-023 SHALL set dp_o = ~dp_i_shadow[index] when visible, 1 when blanked.
REQ-024 SHALL treat a digit as blanked if blank[index] is set, or blink[index] and blink phase = 1, or it is leading-zero suppressed; blanked drives an_o all ones, seg_o 7F, dp_o 1.
REQ-025 SHALL suppress (lz_en_i=1) digit k when it and all digits above k hold nibble 0; digit 0 is never suppressed.
REQ-026 SHALL capture data_i, dp_i, blank_i, blink_i into a pending buffer on load_i and set pend_o the next cycle.
REQ-027 SHALL copy pending to shadow and clear pend_o at frame wrap when pend_o=1; the display uses only the shadow (no mid-frame tearing).
REQ-028 SHALL, when load_i coincides with a commit, commit the old pending contents, load the new values into pending, and keep pend_o=1.
REQ-029 SHALL let a later load_i overwrite pending before commit (last write wins).
REQ-030 SHALL pulse frame_o high for exactly the cycle after each frame wrap.
REQ-031 SHALL toggle blink phase every BLINK_FRAMES frame wraps via a frame counter.
REQ-032 SHALL, while hold_i=1, clear prescaler and index to 0, force an_o all ones, seg_o 7F, dp_o 1, suppress frame_o, and commit pending immediately; loads are still accepted.
REQ-033 SHALL resume at digit 0 with a full SCAN_DIV slot on the first cycle after hold_i deasserts.

Reset
REQ-034 SHALL, on rst_n_i low, asynchronously set an_o all ones, seg_o 7F, dp_o 1, frame_o 0, pend_o 0.
REQ-035 SHALL, on rst_n_i low, clear prescaler, index, blink counter and phase, pending, and shadow to zero.
REQ-036 SHALL honour reset mid-frame or mid-load, discarding pending data; scanning restarts at digit 0.

Verification
REQ-037 SHALL cover scan: DIGITS=8, SCAN_DIV=4, shadow 0x01234567 -> an_o FE,FD,..,7F each held 4 cycles, seg_o 0x07 inverted (78) on digit 0, frame_o every 32 cycles.
REQ-038 SHALL cover tear-free load: load_i mid-frame with 0xFFFFFFFF -> pend_o=1, old digits until wrap, then all seg_o 0E, pend_o=0.
REQ-039 SHALL cover leading-zero: lz_en_i=1, data 0x00000000 -> only digit 0 lit, shows 0 (seg_o 40); data 0x00100000 -> digits 0..5 lit.
REQ-040 SHALL cover blink: BLINK_FRAMES=2, blink_i=0x01 -> digit 0 dark in frames 2-3, 6-7, lit otherwise.
REQ-041 SHALL cover hold and reset: hold_i pulsed mid-slot -> an_o FF, restart at FE; rst_n_i low mid-frame -> outputs at reset values asynchronously, pend_o 0.
REQ-042 SHALL cover the collision: load_i on the wrap cycle -> earlier pending shown, new value shown after the next wrap.
